// File: rtl/regfile_writeback.sv
// Write-port arbiter for the register file: ALU results win, long-latency results queue in a
// small FIFO and drain on idle cycles. Optional forwarding: REGFILE_WB_FORWARD_EN.
module regfile_writeback #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  output logic            RegWrite,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] wd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            fwd1_valid,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_valid,
  output logic [XLEN-1:0] fwd2_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [4:0]      q_rd    [DEPTH];
  logic [XLEN-1:0] q_wd    [DEPTH];
  logic [DEPTH-1:0] q_alive;
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;

  logic alu_wr, push, pop, head_alive;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign alu_wr     = alu_valid && (alu_rd != 5'd0);
  assign lsu_ready  = !reset && (count < DEPTH_C);
  // x0 results and results already superseded by this cycle's ALU write are accepted but dropped
  assign push       = lsu_valid && lsu_ready && (lsu_rd != 5'd0) && !(alu_wr && (lsu_rd == alu_rd));
  assign pop        = !alu_wr && (count != '0);
  assign head_alive = q_alive[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      q_alive <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd[i] <= '0;
        q_wd[i] <= '0;
      end
    end else begin
      // Younger ALU write kills older queued writes to the same register
      if (alu_wr) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_rd[i] == alu_rd) q_alive[i] <= 1'b0;
        end
      end
      if (push) begin
        q_rd[wptr]    <= lsu_rd;
        q_wd[wptr]    <= lsu_wd;
        q_alive[wptr] <= 1'b1;
        wptr          <= ptr_inc(wptr);
      end
      if (pop) rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite <= 1'b0;
      rd       <= '0;
      wd       <= '0;
    end else if (alu_wr) begin
      RegWrite <= 1'b1;
      rd       <= alu_rd;
      wd       <= alu_wd;
    end else if (pop && head_alive) begin
      RegWrite <= 1'b1;
      rd       <= q_rd[rptr];
      wd       <= q_wd[rptr];
    end else begin
      RegWrite <= 1'b0;
    end
  end

`ifdef REGFILE_WB_FORWARD_EN
  assign fwd1_valid = RegWrite && (rd == rs1) && (rs1 != 5'd0);
  assign fwd2_valid = RegWrite && (rd == rs2) && (rs2 != 5'd0);
  assign fwd1_data  = wd;
  assign fwd2_data  = wd;
`else
  logic unused_rs;
  assign unused_rs  = ^{rs1, rs2};
  assign fwd1_valid = 1'b0;
  assign fwd2_valid = 1'b0;
  assign fwd1_data  = '0;
  assign fwd2_data  = '0;
`endif

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side front end for the 32x32 register file: merges register results from two producers into the single write port (RegWrite/rd/wd).
- Producer 1 is the ALU: single-cycle results, always accepted, highest priority.
- Producer 2 is the long-latency unit (load/multiply): valid/ready handshake, buffered in a small FIFO, drained on cycles the ALU does not write.
- Sits between the execute/memory stages and register_file, and enforces write-after-write ordering on the shared port.

Parameters:
- DEPTH, 2, number of LSU result FIFO entries (>=1).
- XLEN, 32, data width of written values.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU result present this cycle
- alu_rd  input  5  ALU destination register
- alu_wd  input  XLEN  ALU result data
- lsu_valid  input  1  long-latency result offered
- lsu_ready  output  1  FIFO can accept; transfer when lsu_valid && lsu_ready
- lsu_rd  input  5  long-latency destination register
- lsu_wd  input  XLEN  long-latency result data
- RegWrite  output  1  write strobe to register_file (registered)
- rd  output  5  write address to register_file (registered)
- wd  output  XLEN  write data to register_file (registered)
- rs1  input  5  decode read address 1 (forwarding compare)
- rs2  input  5  decode read address 2 (forwarding compare)
- fwd1_valid  output  1  rs1 matches the pending output-stage write
- fwd1_data  output  XLEN  forwarded data for rs1
- fwd2_valid  output  1  rs2 matches the pending output-stage write
- fwd2_data  output  XLEN  forwarded data for rs2

Behaviour:
- Reset, asynchronous: RegWrite=0, rd=0, wd=0, FIFO count=0 with pointers at 0, fwd*_valid=0.
- lsu_ready is forced to 0 while reset is high. After reset, lsu_ready = (count < DEPTH), from registered state only; no combinational path from alu_valid or lsu_valid.
- Output stage is a single register. A write selected in cycle N appears on RegWrite/rd/wd in cycle N+1 and lands in the register file at the edge ending N+1.
- Selection each cycle:
  - alu_valid=1 and alu_rd!=0: ALU write is loaded into the output stage.
  - Otherwise, FIFO non-empty: FIFO head is popped into the output stage.
  - Otherwise: RegWrite=0 next cycle; rd and wd hold their previous values.
- x0 filtering: ALU writes with rd=0 are ignored. LSU transfers with lsu_rd=0 complete the handshake but are not enqueued.
- FIFO is circular, DEPTH entries. Read and write pointers wrap modulo DEPTH. Push and pop in the same cycle leave count unchanged. Push is legal only when count<DEPTH, as gated by lsu_ready.
- WAW ordering (ALU results are younger than buffered LSU results):
  - Accepted ALU write to rd=X kills every valid FIFO entry with rd=X. Killed entries are skipped when they reach the head and are never written.
  - A same-cycle LSU transfer with lsu_rd=X and an ALU write to X: the LSU transfer completes and is discarded.
  - A killed entry still occupies its slot until it is popped. A dead head pops in the same cycle as it is reached, at one entry per cycle, without producing RegWrite.
- Simultaneous alu_valid with a non-empty FIFO: the FIFO stalls that cycle and no pop occurs.
- Reset asserted mid-operation: all FIFO contents and the pending output write are discarded immediately.

Optional Feature:
- Macro: REGFILE_WB_FORWARD_EN.
- Defined:
  - fwdK_valid = RegWrite && (rd == rsK) && (rsK != 0), combinational from the output-stage register.
  - fwdK_data = wd.
  - Covers the one-cycle window in which register_file still returns the stale value.
- Undefined: fwd1_valid, fwd2_valid, fwd1_data and fwd2_data are tied to 0. The comparison logic is not built. Ports remain present.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_wd=0xDEADBEEF for one cycle -> next cycle RegWrite=1, rd=5, wd=0xDEADBEEF; following cycle RegWrite=0.
- Three LSU transfers (rd=1,2,3; data 0x11,0x22,0x33) with DEPTH=2 and alu_valid held 1 (rd=10) -> lsu_ready=0 after two accepts; on ALU release, writes rd=1 then rd=2; lsu_ready reasserts and the third transfer follows in order.
- LSU enqueues rd=7 data 0xAA, then ALU writes rd=7 data 0xBB before it drains -> only rd=7/0xBB appears on the port; the dead entry pops without RegWrite.
- lsu_rd=0 transfer and alu_rd=0 write -> handshake completes, count stays 0, RegWrite never asserts.
- Assert reset with FIFO full and RegWrite=1 -> RegWrite=0 immediately, count=0, lsu_ready=0 during reset and 1 after release.
- REGFILE_WB_FORWARD_EN defined, output stage holds rd=9/0x1234, rs1=9, rs2=0 -> fwd1_valid=1, fwd1_data=0x1234, fwd2_valid=0; macro undefined -> all forwarding outputs 0.
